// File: rtl/window_stream_ctrl.sv
// Line-buffer window streamer: KSIZE+1 line memories feed one KSIZE x KSIZE window per pixel with ready/valid.
// Define WINDOW_ZERO_PAD_EN for centred, zero-padded windows; the default build gives legacy wrap-around columns.
//
// state     | meaning
// S_IDLE    | waiting until KSIZE whole lines are buffered
// S_READ    | issuing one window per column, stalled by downstream backpressure
// S_LINE_DONE | pulse o_intr, retire the oldest line, advance rd_sel
module window_stream_ctrl #(
  parameter int DW        = 8,
  parameter int IMG_WIDTH = 512,
  parameter int KSIZE     = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DW-1:0]               i_pixel_data,
  input  logic                        i_pixel_data_valid,
  input  logic                        i_sof,
  output logic                        o_ready,
  output logic [KSIZE*KSIZE*DW-1:0]   o_pixel_data,
  output logic                        o_pixel_data_valid,
  input  logic                        i_ready,
  output logic                        o_intr,
  output logic                        o_overflow,
  input  logic [3:0]                  i_opcode,
  output logic [3:0]                  o_opcode
);
  localparam int NUM_BUF = KSIZE + 1;
  localparam int COLW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int SELW    = $clog2(NUM_BUF);
  localparam int LSW     = $clog2(NUM_BUF + 1);
  localparam int WINW    = KSIZE * KSIZE * DW;
  localparam logic [COLW-1:0] COL_LAST = COLW'(IMG_WIDTH - 1);
  localparam logic [SELW-1:0] SEL_LAST = SELW'(NUM_BUF - 1);
  localparam logic [LSW-1:0]  LS_FULL  = LSW'(NUM_BUF);
  localparam logic [LSW-1:0]  LS_KSIZE = LSW'(KSIZE);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_LINE_DONE} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    mem [NUM_BUF][IMG_WIDTH];
  logic [COLW-1:0]  wr_col, rd_col, wr_col_a;
  logic [SELW-1:0]  wr_sel, rd_sel, wr_sel_a;
  logic [LSW-1:0]   lines_stored;
  logic             issued_all, s1_v, s1_last, o_last;
  logic [WINW-1:0]  s1_data, win_rd;
  logic             sof_evt, wr_en, wr_wrap, adv, issue, line_done;

  function automatic logic [SELW-1:0] sel_inc(input logic [SELW-1:0] s);
    return (s == SEL_LAST) ? '0 : s + 1'b1;
  endfunction

  assign sof_evt   = i_pixel_data_valid & i_sof;
  assign o_ready   = (lines_stored != LS_FULL);
  // A frame-start pixel is always taken: it empties the buffers before landing at buf[0][0].
  assign wr_en     = i_pixel_data_valid & (o_ready | i_sof);
  assign wr_sel_a  = i_sof ? '0 : wr_sel;
  assign wr_col_a  = i_sof ? '0 : wr_col;
  assign wr_wrap   = wr_en & ~i_sof & (wr_col == COL_LAST);
  assign adv       = ~o_pixel_data_valid | i_ready;
  assign issue     = (state == S_READ) & ~issued_all & adv;
  assign line_done = (state == S_LINE_DONE);
  assign o_intr    = line_done;

  always_comb begin
    int row_i;
    int col_i;
    row_i  = 0;
    col_i  = 0;
    win_rd = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int k = 0; k < KSIZE; k++) begin
        row_i = (int'(rd_sel) + r) % NUM_BUF;
`ifdef WINDOW_ZERO_PAD_EN
        col_i = int'(rd_col) - KSIZE / 2 + k;
        if (col_i >= 0 && col_i < IMG_WIDTH)
          win_rd[((r * KSIZE) + k) * DW +: DW] = mem[SELW'(row_i)][COLW'(col_i)];
`else
        col_i = (int'(rd_col) + k) % IMG_WIDTH;
        win_rd[((r * KSIZE) + k) * DW +: DW] = mem[SELW'(row_i)][COLW'(col_i)];
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_sel_a][wr_col_a] <= i_pixel_data;
    if (issue) s1_data <= win_rd;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (lines_stored >= LS_KSIZE) state_nxt = S_READ;
      S_READ:      if (o_pixel_data_valid & i_ready & o_last) state_nxt = S_LINE_DONE;
      S_LINE_DONE: state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (sof_evt) state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= S_IDLE;
      wr_col             <= '0;
      wr_sel             <= '0;
      rd_col             <= '0;
      rd_sel             <= '0;
      lines_stored       <= '0;
      issued_all         <= 1'b0;
      s1_v               <= 1'b0;
      s1_last            <= 1'b0;
      o_last             <= 1'b0;
      o_pixel_data_valid <= 1'b0;
      o_pixel_data       <= '0;
      o_overflow         <= 1'b0;
      o_opcode           <= '0;
    end else begin
      state <= state_nxt;
      if (i_pixel_data_valid & ~o_ready & ~i_sof) o_overflow <= 1'b1;
      if (sof_evt) begin
        wr_col             <= COLW'(1);
        wr_sel             <= '0;
        rd_col             <= '0;
        rd_sel             <= '0;
        lines_stored       <= '0;
        issued_all         <= 1'b0;
        s1_v               <= 1'b0;
        s1_last            <= 1'b0;
        o_last             <= 1'b0;
        o_pixel_data_valid <= 1'b0;
      end else begin
        if (wr_en)   wr_col <= (wr_col == COL_LAST) ? '0 : wr_col + 1'b1;
        if (wr_wrap) wr_sel <= sel_inc(wr_sel);
        lines_stored <= lines_stored + LSW'(wr_wrap) - LSW'(line_done);
        // Stage 1 and the output register move together, so a stall holds both.
        if (adv) begin
          o_pixel_data_valid <= s1_v;
          o_last             <= s1_last;
          if (s1_v) o_pixel_data <= s1_data;
          s1_v    <= issue;
          s1_last <= issue & (rd_col == COL_LAST);
        end
        if (issue) begin
          rd_col <= (rd_col == COL_LAST) ? '0 : rd_col + 1'b1;
          if (rd_col == COL_LAST) issued_all <= 1'b1;
        end
        if (state == S_IDLE && state_nxt == S_READ) begin
          o_opcode   <= i_opcode;
          issued_all <= 1'b0;
        end
        if (line_done) rd_sel <= sel_inc(rd_sel);
      end
    end
  end
endmodule

// File: tb/tb_window_stream_ctrl.sv
// Directed bench for window_stream_ctrl (DW=8, IMG_WIDTH=16, KSIZE=3); expectations follow WINDOW_ZERO_PAD_EN.
module tb_window_stream_ctrl;
  localparam int DW = 8;
  localparam int W = 16;
  localparam int K = 3;
  localparam int WINW = K * K * DW;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [DW-1:0]   i_pixel_data = '0;
  logic            i_pixel_data_valid = 1'b0;
  logic            i_sof = 1'b0;
  logic            o_ready;
  logic [WINW-1:0] o_pixel_data;
  logic            o_pixel_data_valid;
  logic            i_ready = 1'b0;
  logic            o_intr;
  logic            o_overflow;
  logic [3:0]      i_opcode = '0;
  logic [3:0]      o_opcode;

  window_stream_ctrl #(.DW(DW), .IMG_WIDTH(W), .KSIZE(K)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pixel_data(i_pixel_data), .i_pixel_data_valid(i_pixel_data_valid), .i_sof(i_sof),
    .o_ready(o_ready), .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
    .i_ready(i_ready), .o_intr(o_intr), .o_overflow(o_overflow),
    .i_opcode(i_opcode), .o_opcode(o_opcode)
  );

  always #5 i_clk = ~i_clk;

  int tests_run = 0;
  int tests_failed = 0;
  int intr_cnt = 0;
  int stall_err = 0;
  logic [WINW-1:0] q[$];
  logic            prev_stall = 1'b0;
  logic            prev_clr = 1'b0;
  logic [WINW-1:0] prev_data = '0;

  // Records accepted windows and o_intr pulses; flags any change of a stalled window.
  always @(negedge i_clk) begin
    if (prev_stall && !prev_clr && (!o_pixel_data_valid || o_pixel_data !== prev_data))
      stall_err++;
    if (o_pixel_data_valid && i_ready) q.push_back(o_pixel_data);
    if (o_intr) intr_cnt++;
    prev_stall = o_pixel_data_valid && !i_ready;
    prev_clr   = i_rst || (i_sof && i_pixel_data_valid);
    prev_data  = o_pixel_data;
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pix(input int off, input int line, input int col);
    return DW'(off + line * W + col);
  endfunction

  function automatic logic [WINW-1:0] exp_win(input int off, input int line0, input int col);
    logic [WINW-1:0] w;
    int c;
    w = '0;
    for (int r = 0; r < K; r++) begin
      for (int k = 0; k < K; k++) begin
`ifdef WINDOW_ZERO_PAD_EN
        c = col - K / 2 + k;
        if (c >= 0 && c < W) w[((r * K) + k) * DW +: DW] = pix(off, line0 + r, c);
`else
        c = (col + k) % W;
        w[((r * K) + k) * DW +: DW] = pix(off, line0 + r, c);
`endif
      end
    end
    return w;
  endfunction

  task automatic send_line(input int off, input int line, input logic sof);
    for (int c = 0; c < W; c++) begin
      i_pixel_data       = pix(off, line, c);
      i_pixel_data_valid = 1'b1;
      i_sof              = sof && (c == 0);
      tick();
    end
    i_pixel_data_valid = 1'b0;
    i_sof              = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_pixel_data_valid = 1'b0;
    i_sof = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    q.delete();
    intr_cnt = 0;
    stall_err = 0;
  endtask

  task automatic wait_intr(input int n, input string tag);
    for (int i = 0; i < 200 && intr_cnt < n; i++) tick();
    check(tag, 72'(intr_cnt), 72'(n));
  endtask

  task automatic check_line(input string tag, input int base, input int off, input int line0);
    for (int i = 0; i < W; i++)
      check(tag, (base + i < q.size()) ? q[base + i] : '0, exp_win(off, line0, i));
  endtask

  logic [WINW-1:0] win;
  int qs;
  logic [3:0] pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    // T1 reset
    i_rst = 1'b1;
    tick();
    tick();
    check("t1_valid", 72'(o_pixel_data_valid), 72'(0));
    check("t1_intr", 72'(o_intr), 72'(0));
    check("t1_overflow", 72'(o_overflow), 72'(0));
    check("t1_ready", 72'(o_ready), 72'(1));
    check("t1_opcode", 72'(o_opcode), 72'(0));
    check("t1_data", 72'(o_pixel_data), 72'(0));

    // T2 three lines, free-flowing output
    do_reset();
    i_ready = 1'b1;
    i_opcode = 4'h5;
    send_line(0, 0, 1'b0);
    send_line(0, 1, 1'b0);
    send_line(0, 2, 1'b0);
    tick();
    i_opcode = 4'h9;
    tick();
    check("t2_opcode_latched", 72'(o_opcode), 72'(4'h5));
    wait_intr(1, "t2_intr_wait");
    for (int i = 0; i < 10; i++) tick();
    check("t2_intr_once", 72'(intr_cnt), 72'(1));
    check("t2_count", 72'(q.size()), 72'(W));
    check("t2_opcode_held", 72'(o_opcode), 72'(4'h5));
    win = (q.size() > 15) ? q[0] : '0;
`ifdef WINDOW_ZERO_PAD_EN
    check("t2_first", win, 72'h212000_111000_010000);
    win = (q.size() > 15) ? q[5] : '0;
    check("t2_centre", 72'(win[39:32]), 72'(8'h15));
    win = (q.size() > 15) ? q[15] : '0;
    check("t2_last", win, 72'h002F2E_001F1E_000F0E);
`else
    check("t2_first", win, 72'h222120_121110_020100);
    win = (q.size() > 15) ? q[5] : '0;
    check("t2_centre", 72'(win[39:32]), 72'(8'h16));
    win = (q.size() > 15) ? q[15] : '0;
    check("t2_last", win, 72'h21202F_11101F_01000F);
`endif
    check_line("t2_win", 0, 0, 0);
    check("t2_ready", 72'(o_ready), 72'(1));

    // T4 backpressure pattern over a full line
    do_reset();
    i_ready = 1'b0;
    send_line(0, 0, 1'b0);
    send_line(0, 1, 1'b0);
    send_line(0, 2, 1'b0);
    for (int i = 0; i < 400 && intr_cnt == 0; i++) begin
      i_ready = pat[i % 4][0];
      tick();
    end
    i_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("t4_intr_once", 72'(intr_cnt), 72'(1));
    check("t4_count", 72'(q.size()), 72'(W));
    check_line("t4_win", 0, 0, 0);
    check("t4_stable", 72'(stall_err), 72'(0));

    // T5 buffers full, overflow, recovery
    do_reset();
    i_ready = 1'b0;
    for (int l = 0; l < 4; l++) send_line(0, l, 1'b0);
    check("t5_full_ready", 72'(o_ready), 72'(0));
    i_pixel_data = 8'hAB;
    i_pixel_data_valid = 1'b1;
    tick();
    i_pixel_data_valid = 1'b0;
    check("t5_overflow", 72'(o_overflow), 72'(1));
    check("t5_still_full", 72'(o_ready), 72'(0));
    i_ready = 1'b1;
    wait_intr(1, "t5_intr1");
    tick();
    check("t5_ready_back", 72'(o_ready), 72'(1));
    wait_intr(2, "t5_intr2");
    send_line(0, 4, 1'b0);
    wait_intr(3, "t5_intr3");
    for (int i = 0; i < 5; i++) tick();
    check("t5_count", 72'(q.size()), 72'(3 * W));
    check_line("t5_line0", 0, 0, 0);
    check_line("t5_line1", W, 0, 1);
    check_line("t5_line2", 2 * W, 0, 2);
    check("t5_overflow_sticky", 72'(o_overflow), 72'(1));
    check("t5_stable", 72'(stall_err), 72'(0));

    // T6 frame restart in the middle of a read line
    do_reset();
    i_ready = 1'b1;
    send_line(0, 0, 1'b0);
    send_line(0, 1, 1'b0);
    send_line(0, 2, 1'b0);
    for (int i = 0; i < 100 && q.size() < 5; i++) tick();
    i_ready = 1'b0;
    qs = q.size();
    check("t6_partial", 72'(qs), 72'(5));
    send_line(128, 0, 1'b1);
    send_line(128, 1, 1'b0);
    send_line(128, 2, 1'b0);
    check("t6_no_intr", 72'(intr_cnt), 72'(0));
    check("t6_overflow", 72'(o_overflow), 72'(0));
    i_ready = 1'b1;
    wait_intr(1, "t6_intr");
    for (int i = 0; i < 5; i++) tick();
    check("t6_count", 72'(q.size() - qs), 72'(W));
    check_line("t6_win", qs, 128, 0);
    check("t6_stable", 72'(stall_err), 72'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
